// File: rtl/ifetch.sv
// Instruction fetch stage: sequential PC generation, single-outstanding word
// fetch to instruction memory, and an in-order {pc, instr} queue toward IF/ID.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_valid
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          busy;
  logic          discard;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic accept;
  logic resp;
  logic push;
  logic pop;
  logic unused_target_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Memory handshake: a request transfers on a cycle with mem_req && mem_ready;
  // mem_addr holds while mem_req waits for ready (only a redirect may withdraw it);
  // exactly one mem_rvalid returns per accepted request, in order, no earlier than
  // the cycle after acceptance. Taking a new request in the cycle rvalid arrives
  // keeps fetches back-to-back with only one request in flight.
  assign mem_req = !reset && !branch_taken
                && ((count + CW'(busy)) < DEPTH_C)
                && (!busy || mem_rvalid);
  assign mem_addr = pc;

  assign accept = mem_req && mem_ready;
  assign resp   = mem_rvalid && busy;
  assign push   = resp && !discard && !branch_taken;
  assign pop    = out_valid && !stall && !branch_taken;

  assign unused_target_bits = ^branch_target[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      req_pc  <= '0;
      busy    <= 1'b0;
      discard <= 1'b0;
    end else if (branch_taken) begin
      // A response landing in the redirect cycle retires the request outright;
      // otherwise the still-pending one must be dropped when it returns.
      pc      <= {branch_target[31:2], 2'b00};
      busy    <= busy && !mem_rvalid;
      discard <= busy && !mem_rvalid;
    end else if (accept) begin
      req_pc  <= pc;
      pc      <= pc + 32'd4;
      busy    <= 1'b1;
      discard <= 1'b0;
    end else if (resp) begin
      busy    <= 1'b0;
      discard <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || branch_taken) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= req_pc;
        q_instr[wr_ptr] <= mem_rdata;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? q_pc[rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? q_instr[rd_ptr] : 32'h0;

  // The request gating reserves a slot for the in-flight fetch, so a full push is a bug.
  assert property (@(posedge clk) disable iff (reset) push |-> (count != DEPTH_C))
    else $error("ifetch: push into full queue");

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: hand-traced per-cycle vectors plus an in-order
// scoreboard on every pop, against a small configurable-latency memory model.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;

  int          resp_delay;
  logic        pend  = 1'b0;
  int          wcnt  = 0;
  logic [31:0] paddr = 32'h0;
  logic        found;

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_valid     (out_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic reload(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // memory model: resp_delay cycles from accept to rvalid, unaware of DUT reset
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pend) begin
      if (wcnt <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= instr_of(paddr);
        pend       <= 1'b0;
      end else begin
        wcnt <= wcnt - 1;
      end
    end
    if (mem_req && mem_ready) begin
      if (resp_delay <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= instr_of(mem_addr);
      end else begin
        pend  <= 1'b1;
        wcnt  <= resp_delay - 1;
        paddr <= mem_addr;
      end
    end
  end

  // scoreboard: every consumed instruction must be the next expected PC
  always @(negedge clk) begin
    #3;
    if (reset === 1'b0 && out_valid === 1'b1 && stall === 1'b0 && branch_taken === 1'b0) begin
      if (exp_q.size() > 0) mon_pc = exp_q.pop_front();
      else mon_pc = 32'hDEAD_BEEF;
      chk("pop_pc", out_pc, mon_pc);
      chk("pop_instr", out_instr, instr_of(mon_pc));
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    mem_ready = 1'b1; resp_delay = 1;
    reload(32'h0);
    cyc(); cyc();
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);

    // reset release, back-to-back fetch
    reset = 1'b0; #1;
    chk("c1_req", mem_req, 1'b1);
    chk("c1_addr", mem_addr, 32'h0);
    cyc(); #1;
    chk("c2_req", mem_req, 1'b1);
    chk("c2_addr", mem_addr, 32'h4);
    chk("c2_ov", out_valid, 1'b0);
    cyc(); #1;
    chk("c3_ov", out_valid, 1'b1);
    chk("c3_pc", out_pc, 32'h0);
    chk("c3_instr", out_instr, 32'h1357_9BDF);
    chk("c3_req_full", mem_req, 1'b0);
    cyc(); #1;
    chk("c4_pc", out_pc, 32'h4);
    chk("c4_instr", out_instr, 32'h1357_9BDB);
    chk("c4_addr", mem_addr, 32'h8);

    // stall for 5 cycles
    cyc(); stall = 1'b1; #1;
    chk("s1_ov", out_valid, 1'b0);
    chk("s1_addr", mem_addr, 32'hC);
    cyc(); #1;
    chk("s2_pc", out_pc, 32'h8);
    chk("s2_req", mem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("s_hold_pc", out_pc, 32'h8);
      chk("s_hold_req", mem_req, 1'b0);
    end
    cyc(); stall = 1'b0; #1;
    chk("s_rel_pc", out_pc, 32'h8);
    chk("s_rel_req", mem_req, 1'b0);
    cyc(); #1;
    chk("s_rel2_pc", out_pc, 32'hC);
    chk("s_rel2_addr", mem_addr, 32'h10);

    // mem_ready low for 3 cycles
    cyc(); mem_ready = 1'b0; #1;
    chk("nr1_ov", out_valid, 1'b0);
    chk("nr1_addr", mem_addr, 32'h14);
    cyc(); #1;
    chk("nr2_pc", out_pc, 32'h10);
    chk("nr2_req", mem_req, 1'b1);
    chk("nr2_addr", mem_addr, 32'h14);
    cyc(); #1;
    chk("nr3_addr", mem_addr, 32'h14);
    cyc(); mem_ready = 1'b1; #1;
    chk("nr4_addr", mem_addr, 32'h14);
    cyc(); #1;
    chk("nr5_addr", mem_addr, 32'h18);
    cyc(); #1;
    chk("nr6_pc", out_pc, 32'h14);
    cyc(); resp_delay = 2; #1;
    chk("nr7_pc", out_pc, 32'h18);
    chk("nr7_addr", mem_addr, 32'h1C);

    // redirect while a response is outstanding
    cyc(); branch_taken = 1'b1; branch_target = 32'h103; reload(32'h100); #1;
    chk("br_req", mem_req, 1'b0);
    chk("br_ov", out_valid, 1'b0);
    cyc(); branch_taken = 1'b0; #1;
    chk("br1_ov", out_valid, 1'b0);
    chk("br1_req", mem_req, 1'b1);
    chk("br1_addr", mem_addr, 32'h100);
    cyc(); resp_delay = 1; #1;
    chk("br2_req", mem_req, 1'b0);
    chk("br2_ov", out_valid, 1'b0);
    cyc(); #1;
    chk("br3_addr", mem_addr, 32'h104);
    chk("br3_ov", out_valid, 1'b0);

    // redirect in the same cycle as rvalid, head present
    cyc(); branch_taken = 1'b1; branch_target = 32'h200; reload(32'h200); #1;
    chk("bs_pc", out_pc, 32'h100);
    chk("bs_instr", out_instr, 32'h1357_9ADF);
    chk("bs_rvalid_req", mem_req, 1'b0);
    cyc(); branch_taken = 1'b0; #1;
    chk("bs1_ov", out_valid, 1'b0);
    chk("bs1_req", mem_req, 1'b1);
    chk("bs1_addr", mem_addr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(); #1;
      if (out_valid) found = 1'b1;
    end
    chk("bs_first_ov", out_valid, 1'b1);
    chk("bs_first_pc", out_pc, 32'h200);

    // reset while busy, stale response after reset
    resp_delay = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(); #1;
      if (mem_req && mem_ready) found = 1'b1;
    end
    chk("rb_pre_req", mem_req, 1'b1);
    cyc(); reset = 1'b1; #1;
    chk("rb_rst_req", mem_req, 1'b0);
    cyc(); reset = 1'b0; reload(32'h0); #1;
    chk("rb1_ov", out_valid, 1'b0);
    chk("rb1_req", mem_req, 1'b1);
    chk("rb1_addr", mem_addr, 32'h0);
    cyc(); #1;
    chk("rb2_ov", out_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(); #1;
      if (out_valid) found = 1'b1;
    end
    chk("rb_first_ov", out_valid, 1'b1);
    chk("rb_first_pc", out_pc, 32'h0);
    cyc(); cyc();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
